btn_updown_counter: RTL

- Input-side companion to the free-running LED counter: it reads two pushbuttons (UP, DOWN) instead of driving a display.
- Each button is synchronised, debounced and edge-detected. Each clean press steps a BITS-wide value up or down.
- The value feeds the LED bank or any other consumer of a user-set count.

---
 rtl/btn_updown_counter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/btn_updown_counter.sv
// Two-button up/down counter: each raw button is synchronised, debounced and
// edge-detected. Define AUTOREPEAT_EN to make a held button repeat its step.
//
// state | meaning (per button, stable level s_q)
// 0     | button considered released, counting mismatches toward press
// 1     | button considered pressed, counting mismatches toward release

module btn_updown_cond #(
    parameter int LOG2DEBOUNCE = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn_i,
    output logic step_o
);

    localparam logic [LOG2DEBOUNCE-1:0] CNT_MAX = '1;

    logic                    sync1_q;
    logic                    sync2_q;
    logic                    s_q;
    logic                    s_prev_q;
    logic [LOG2DEBOUNCE-1:0] cnt_q;
    logic                    rise;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            s_q      <= 1'b0;
            s_prev_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            s_prev_q <= s_q;
            // Any cycle agreeing with the stable level restarts the window.
            if (sync2_q == s_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                s_q   <= sync2_q;
                cnt_q <= '0;
            end
        end
    end

    assign rise = s_q & ~s_prev_q;

`ifdef AUTOREPEAT_EN
    localparam int RW = LOG2DEBOUNCE + 4;
    localparam logic [RW-1:0] RPT_FIRST = '1;
    localparam logic [RW-1:0] RPT_NEXT  = {2'b00, {(LOG2DEBOUNCE + 2){1'b1}}};

    logic [RW-1:0] rpt_q;
    logic          rpt_fire;

    // Down-counter reloaded on the press; each terminal count is one repeat.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rpt_q <= '0;
        end else if (!s_q) begin
            rpt_q <= '0;
        end else if (rise) begin
            rpt_q <= RPT_FIRST;
        end else if (rpt_q == '0) begin
            rpt_q <= RPT_NEXT;
        end else begin
            rpt_q <= rpt_q - 1'b1;
        end
    end

    assign rpt_fire = s_q & ~rise & (rpt_q == '0);
    assign step_o   = rise | rpt_fire;
`else
    assign step_o = rise;
`endif

endmodule

module btn_updown_counter #(
    parameter int BITS         = 8,
    parameter int LOG2DEBOUNCE = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            BTN_UP,
    input  logic            BTN_DN,
    output logic [BITS-1:0] value,
    output logic            up_pulse,
    output logic            dn_pulse
);

    logic            up_step;
    logic            dn_step;
    logic [BITS-1:0] value_q;
    logic [BITS-1:0] value_d;
    logic            up_pulse_q;
    logic            dn_pulse_q;

    btn_updown_cond #(.LOG2DEBOUNCE(LOG2DEBOUNCE)) u_cond_up (
        .clk    (clk),
        .resetn (resetn),
        .btn_i  (BTN_UP),
        .step_o (up_step)
    );

    btn_updown_cond #(.LOG2DEBOUNCE(LOG2DEBOUNCE)) u_cond_dn (
        .clk    (clk),
        .resetn (resetn),
        .btn_i  (BTN_DN),
        .step_o (dn_step)
    );

    // Simultaneous steps cancel; arithmetic wraps modulo 2^BITS.
    always_comb begin
        value_d = value_q;
        case ({up_step, dn_step})
            2'b10:   value_d = value_q + 1'b1;
            2'b01:   value_d = value_q - 1'b1;
            default: value_d = value_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value_q    <= '0;
            up_pulse_q <= 1'b0;
            dn_pulse_q <= 1'b0;
        end else begin
            value_q    <= value_d;
            up_pulse_q <= up_step;
            dn_pulse_q <= dn_step;
        end
    end

    assign value    = value_q;
    assign up_pulse = up_pulse_q;
    assign dn_pulse = dn_pulse_q;

endmodule
